// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter and sequencer that shares one single-port memory between
// instruction fetch and data load/store, using a request/ack/valid handshake.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  fetch_req,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic                  fetch_ack,
    output logic                  fetch_valid,
    output logic [DATA_WIDTH-1:0] fetch_rdata,
    input  logic                  data_req,
    input  logic                  data_we,
    input  logic [ADDR_WIDTH-1:0] data_addr,
    input  logic [DATA_WIDTH-1:0] data_wdata,
    output logic                  data_ack,
    output logic                  data_valid,
    output logic [DATA_WIDTH-1:0] data_rdata,
    output logic                  mem_enable,
    output logic                  mem_writeEnable,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_writeData,
    input  logic [DATA_WIDTH-1:0] mem_readData
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic GNT_FETCH = 1'b0;
    localparam logic GNT_DATA  = 1'b1;

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_grant;
    logic                  r_last_grant;
    logic                  r_mem_enable;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_address;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic                  r_fetch_ack;
    logic                  r_data_ack;
    logic                  r_fetch_valid;
    logic                  r_data_valid;

    logic                  w_any_req;
    logic                  w_sel_data;
    logic                  w_grant_now;
    logic                  w_resp_fetch;
    logic                  w_resp_data;

    assign w_any_req = fetch_req | data_req;

    // On contention the requester that did not win last time gets the port.
    assign w_sel_data = data_req & (~fetch_req | (r_last_grant == GNT_FETCH));

    assign w_resp_fetch = (r_state == ST_ACCESS) && (r_grant == GNT_FETCH);
    assign w_resp_data  = (r_state == ST_ACCESS) && (r_grant == GNT_DATA);

    // Next-state and grant decision; arbitration only outside the ACCESS cycle.
    always_comb begin
        w_state_next = r_state;
        w_grant_now  = 1'b0;
        case (r_state)
            ST_IDLE, ST_RESP: begin
                if (w_any_req) begin
                    w_state_next = ST_ACCESS;
                    w_grant_now  = 1'b1;
                end else begin
                    w_state_next = ST_IDLE;
                    w_grant_now  = 1'b0;
                end
            end
            ST_ACCESS: begin
                w_state_next = ST_RESP;
                w_grant_now  = 1'b0;
            end
            default: begin
                w_state_next = ST_IDLE;
                w_grant_now  = 1'b0;
            end
        endcase
    end

    // State register, grant bookkeeping and registered memory/handshake outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_grant       <= GNT_FETCH;
            r_last_grant  <= GNT_FETCH;
            r_mem_enable  <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_address <= '0;
            r_mem_wdata   <= '0;
            r_fetch_ack   <= 1'b0;
            r_data_ack    <= 1'b0;
            r_fetch_valid <= 1'b0;
            r_data_valid  <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_fetch_valid <= w_resp_fetch;
            r_data_valid  <= w_resp_data;
            if (w_grant_now) begin
                r_grant       <= w_sel_data;
                r_last_grant  <= w_sel_data;
                r_mem_enable  <= 1'b1;
                r_mem_we      <= w_sel_data & data_we;
                r_mem_address <= w_sel_data ? data_addr : fetch_addr;
                r_mem_wdata   <= w_sel_data ? data_wdata : '0;
                r_fetch_ack   <= ~w_sel_data;
                r_data_ack    <= w_sel_data;
            end else begin
                r_mem_enable  <= 1'b0;
                r_mem_we      <= 1'b0;
                r_fetch_ack   <= 1'b0;
                r_data_ack    <= 1'b0;
            end
        end
    end

    assign fetch_ack       = r_fetch_ack;
    assign data_ack        = r_data_ack;
    assign fetch_valid     = r_fetch_valid;
    assign data_valid      = r_data_valid;
    assign mem_enable      = r_mem_enable;
    assign mem_writeEnable = r_mem_we;
    assign mem_address     = r_mem_address;
    assign mem_writeData   = r_mem_wdata;

    // Registered memory output is already aligned with the RESP cycle.
    assign fetch_rdata = mem_readData;
    assign data_rdata  = mem_readData;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios with literal
// expectations plus randomized traffic against a transaction-level model.
module tb_mem_port_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        fetch_req;
    logic [15:0] fetch_addr;
    logic        fetch_ack;
    logic        fetch_valid;
    logic [15:0] fetch_rdata;
    logic        data_req;
    logic        data_we;
    logic [15:0] data_addr;
    logic [15:0] data_wdata;
    logic        data_ack;
    logic        data_valid;
    logic [15:0] data_rdata;
    logic        mem_enable;
    logic        mem_writeEnable;
    logic [15:0] mem_address;
    logic [15:0] mem_writeData;
    logic [15:0] mem_readData;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clock = ~clock;

    mem_port_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) dut (
        .clock(clock), .reset(reset),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(fetch_ack),
        .fetch_valid(fetch_valid), .fetch_rdata(fetch_rdata),
        .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_ack(data_ack), .data_valid(data_valid),
        .data_rdata(data_rdata),
        .mem_enable(mem_enable), .mem_writeEnable(mem_writeEnable),
        .mem_address(mem_address), .mem_writeData(mem_writeData),
        .mem_readData(mem_readData)
    );

    function automatic logic [15:0] init_word(input logic [15:0] a);
        if (a == 16'h0010)      return 16'hBEEF;
        else if (a < 16'h0004)  return 16'hA000 + a;
        else                    return a ^ 16'h5A5A;
    endfunction

    // Memory with one-cycle registered read; unwritten words hold init_word().
    bit [15:0] mem_arr [0:65535];
    bit        mem_wr  [0:65535];
    always @(posedge clock) begin
        if (mem_enable) begin
            if (mem_writeEnable) begin
                mem_arr[mem_address] <= mem_writeData;
                mem_wr[mem_address]  <= 1'b1;
            end else begin
                mem_readData <= mem_wr[mem_address] ? mem_arr[mem_address] : init_word(mem_address);
            end
        end
    end

    // Transaction-level model: a grant may happen at any edge not ending an
    // ack cycle; the ack shows one cycle later and the valid the cycle after.
    bit        m_on, m_fack, m_dack, m_fval, m_dval, m_en, m_we, m_last_data;
    bit [15:0] m_addr, m_wdata, m_pend_rd, m_exp_rd;
    bit        m_pend_wr, m_exp_wr;
    bit [15:0] ref_mem [0:65535];
    bit        ref_wr  [0:65535];
    wire        m_pick     = data_req && (!fetch_req || !m_last_data);
    wire [15:0] m_sel_addr = m_pick ? data_addr : fetch_addr;

    always @(posedge clock) begin
        m_on <= 1'b1;
        if (reset) begin
            m_fack <= 1'b0; m_dack <= 1'b0; m_fval <= 1'b0; m_dval <= 1'b0;
            m_en <= 1'b0; m_we <= 1'b0; m_addr <= 16'h0000; m_wdata <= 16'h0000;
            m_last_data <= 1'b0;
        end else begin
            m_fval   <= m_fack;
            m_dval   <= m_dack;
            m_exp_rd <= m_pend_rd;
            m_exp_wr <= m_pend_wr;
            if (!(m_fack || m_dack) && (fetch_req || data_req)) begin
                m_fack      <= !m_pick;
                m_dack      <= m_pick;
                m_en        <= 1'b1;
                m_we        <= m_pick && data_we;
                m_addr      <= m_sel_addr;
                m_wdata     <= m_pick ? data_wdata : 16'h0000;
                m_last_data <= m_pick;
                m_pend_wr   <= m_pick && data_we;
                m_pend_rd   <= ref_wr[m_sel_addr] ? ref_mem[m_sel_addr] : init_word(m_sel_addr);
                if (m_pick && data_we) begin
                    ref_mem[data_addr] <= data_wdata;
                    ref_wr[data_addr]  <= 1'b1;
                end
            end else begin
                m_fack <= 1'b0; m_dack <= 1'b0; m_en <= 1'b0; m_we <= 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        if (m_on) begin
            chk("fetch_ack", {31'd0, fetch_ack}, {31'd0, m_fack});
            chk("data_ack", {31'd0, data_ack}, {31'd0, m_dack});
            chk("fetch_valid", {31'd0, fetch_valid}, {31'd0, m_fval});
            chk("data_valid", {31'd0, data_valid}, {31'd0, m_dval});
            chk("mem_enable", {31'd0, mem_enable}, {31'd0, m_en});
            chk("mem_we", {31'd0, mem_writeEnable}, {31'd0, m_we});
            chk("mem_address", {16'd0, mem_address}, {16'd0, m_addr});
            chk("mem_wdata", {16'd0, mem_writeData}, {16'd0, m_wdata});
            if (m_fval) chk("fetch_rdata", {16'd0, fetch_rdata}, {16'd0, m_exp_rd});
            if (m_dval && !m_exp_wr) chk("data_rdata", {16'd0, data_rdata}, {16'd0, m_exp_rd});
        end
    endtask

    // One cycle: compare at the falling edge, return just after the next rise.
    task automatic tick();
        @(negedge clock);
        compare_model();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; fetch_req = 1'b0; fetch_addr = 16'h0000;
        data_req = 1'b0; data_we = 1'b0; data_addr = 16'h0000; data_wdata = 16'h0000;
        tick(); tick(); tick();
        chk("rst_en", {31'd0, mem_enable}, 32'd0);
        chk("rst_addr", {16'd0, mem_address}, 32'd0);
        reset = 1'b0;

        // Single fetch.
        fetch_req = 1'b1; fetch_addr = 16'h0010;
        tick();
        chk("sf_ack", {31'd0, fetch_ack}, 32'd1);
        chk("sf_en", {31'd0, mem_enable}, 32'd1);
        chk("sf_addr", {16'd0, mem_address}, 32'h0010);
        fetch_req = 1'b0;
        tick();
        chk("sf_valid", {31'd0, fetch_valid}, 32'd1);
        chk("sf_rdata", {16'd0, fetch_rdata}, 32'hBEEF);
        tick();
        chk("sf_idle_en", {31'd0, mem_enable}, 32'd0);
        chk("sf_idle_valid", {31'd0, fetch_valid}, 32'd0);

        // Write then read back.
        data_req = 1'b1; data_we = 1'b1; data_addr = 16'h0200; data_wdata = 16'h1234;
        tick();
        chk("wr_ack", {31'd0, data_ack}, 32'd1);
        chk("wr_we", {31'd0, mem_writeEnable}, 32'd1);
        data_req = 1'b0; data_we = 1'b0;
        tick();
        chk("wr_valid", {31'd0, data_valid}, 32'd1);
        chk("wr_we_off", {31'd0, mem_writeEnable}, 32'd0);
        data_req = 1'b1;
        tick();
        chk("rd_ack", {31'd0, data_ack}, 32'd1);
        data_req = 1'b0;
        tick();
        chk("rd_valid", {31'd0, data_valid}, 32'd1);
        chk("rd_rdata", {16'd0, data_rdata}, 32'h1234);

        // Contention: grants alternate starting with data after reset.
        do_reset();
        fetch_req = 1'b1; fetch_addr = 16'h0010;
        data_req = 1'b1; data_we = 1'b0; data_addr = 16'h0011;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("ct_dack", {31'd0, data_ack}, (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("ct_fack", {31'd0, fetch_ack}, (i % 2 == 1) ? 32'd1 : 32'd0);
            tick();
        end
        fetch_req = 1'b0; data_req = 1'b0;
        tick();

        // Back-to-back fetches.
        fetch_req = 1'b1; fetch_addr = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bb_ack", {31'd0, fetch_ack}, 32'd1);
            if (i < 3) fetch_addr = 16'(i + 1);
            else       fetch_req = 1'b0;
            tick();
            chk("bb_valid", {31'd0, fetch_valid}, 32'd1);
            chk("bb_rdata", {16'd0, fetch_rdata}, 32'hA000 + 32'(i));
        end

        // Idle: nothing moves, address holds.
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle_en", {30'd0, mem_enable, mem_writeEnable}, 32'd0);
            chk("idle_hs", {28'd0, fetch_ack, data_ack, fetch_valid, data_valid}, 32'd0);
            chk("idle_addr", {16'd0, mem_address}, 32'h0003);
        end

        // Reset during ACCESS, then during RESP.
        fetch_req = 1'b1; fetch_addr = 16'h0010;
        tick();
        reset = 1'b1; fetch_req = 1'b0;
        tick();
        chk("ra_en", {31'd0, mem_enable}, 32'd0);
        chk("ra_valid", {31'd0, fetch_valid}, 32'd0);
        reset = 1'b0;
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        tick();
        chk("rr_valid_pre", {31'd0, fetch_valid}, 32'd1);
        reset = 1'b1;
        tick();
        chk("rr_valid", {31'd0, fetch_valid}, 32'd0);
        chk("rr_en", {31'd0, mem_enable}, 32'd0);
        reset = 1'b0;
        tick();

        // Randomized traffic; operands held until the model's ack.
        for (int c = 0; c < 1500; c++) begin
            if (!fetch_req || m_fack) begin
                fetch_req  = ($urandom_range(0, 2) != 0);
                fetch_addr = 16'($urandom_range(0, 31));
            end
            if (!data_req || m_dack) begin
                data_req   = ($urandom_range(0, 2) != 0);
                data_we    = ($urandom_range(0, 1) == 1);
                data_addr  = 16'($urandom_range(0, 31));
                data_wdata = 16'($urandom);
            end
            reset = ($urandom_range(0, 99) == 0);
            tick();
        end
        reset = 1'b0; fetch_req = 1'b0; data_req = 1'b0;
        for (int i = 0; i < 4; i++) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
